// File: rtl/hazard_unit.sv
// OTTER pipeline hazard controller: load-use stalls, branch flushes,
// dmem freeze and saturating stall/flush performance counters.
module hazard_unit #(
  parameter int REG_W           = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32,
  parameter int X0_HAZARD       = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [2:0] LU_LOAD = 3'(LOAD_USE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_lu_cnt;
  logic [2:0]       w_next_lu;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_rd_ok;
  logic             w_lu_hit;

  assign w_rd_ok  = (X0_HAZARD != 0) || (ex_rd != '0);
  assign w_lu_hit = ex_mem_read && w_rd_ok &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    w_next_state = r_state;
    w_next_lu    = r_lu_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (RST) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      w_stall_inc = 1'b1;
    end else if (ex_branch_taken) begin
      // squashing the dependent instruction makes any load-use moot
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      w_next_state = RUN;
      w_next_lu    = 3'd0;
      w_flush_inc  = 1'b1;
    end else if (r_state == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall_inc  = 1'b1;
      w_next_lu    = r_lu_cnt - 3'd1;
      if (r_lu_cnt == 3'd1) w_next_state = RUN;
    end else if (w_lu_hit) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall_inc  = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        w_next_state = LU_STALL;
        w_next_lu    = LU_LOAD;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= RUN;
      r_lu_cnt <= 3'd0;
    end else begin
      r_state  <= w_next_state;
      r_lu_cnt <= w_next_lu;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (3-cycle/4-bit
// counters and 1-cycle/32-bit counters) driven by shared directed vectors.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_mem_read = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       dmem_busy = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        a_pc, a_ifid, a_idex, a_bub, a_iff, a_idf;
  logic        b_pc, b_ifid, b_idex, b_bub, b_iff, b_idf;
  logic [3:0]  a_sc, a_fc;
  logic [31:0] b_sc, b_fc;

  hazard_unit #(
    .REG_W(5), .LOAD_USE_CYCLES(3), .CNT_W(4), .X0_HAZARD(0)
  ) dut_a (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .cnt_clr(cnt_clr),
    .pc_write(a_pc), .if_id_write(a_ifid), .id_ex_write(a_idex),
    .id_ex_bubble(a_bub), .if_id_flush(a_iff), .id_ex_flush(a_idf),
    .stall_count(a_sc), .flush_count(a_fc)
  );

  hazard_unit #(
    .REG_W(5), .LOAD_USE_CYCLES(1), .CNT_W(32), .X0_HAZARD(0)
  ) dut_b (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .cnt_clr(cnt_clr),
    .pc_write(b_pc), .if_id_write(b_ifid), .id_ex_write(b_idex),
    .id_ex_bubble(b_bub), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .stall_count(b_sc), .flush_count(b_fc)
  );

  always #5 CLK = ~CLK;

  // {pc_write, if_id_write, id_ex_write, bubble, if_id_flush, id_ex_flush}
  localparam logic [5:0] C_RUN = 6'b111000;
  localparam logic [5:0] C_LU  = 6'b001100;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_FL  = 6'b111011;
  localparam logic [5:0] C_RST = 6'b000100;

  typedef struct {
    string      name;
    logic [5:0] ca;
    logic [5:0] cb;
    int         sa;
    int         fa;
    int         sb;
    int         fb;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string n, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, req);
    end
  endtask

  // Monitor: every cycle the DUTs present a full set of outputs.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, ".ctl_a"},
            int'({a_pc, a_ifid, a_idex, a_bub, a_iff, a_idf}), int'(e.ca));
        chk({e.name, ".ctl_b"},
            int'({b_pc, b_ifid, b_idex, b_bub, b_iff, b_idf}), int'(e.cb));
        chk({e.name, ".stall_a"}, int'(a_sc), e.sa);
        chk({e.name, ".flush_a"}, int'(a_fc), e.fa);
        chk({e.name, ".stall_b"}, int'(b_sc), e.sb);
        chk({e.name, ".flush_b"}, int'(b_fc), e.fb);
      end
    end
  end

  // Drive one cycle of inputs and push what both DUTs must show.
  task automatic vec(
    input string n, input bit rst,
    input bit hit, input bit br, input bit busy, input bit clr,
    input logic [5:0] ca, input logic [5:0] cb,
    input int sa, input int fa, input int sbv, input int fb
  );
    exp_t e;
    @(negedge CLK);
    #1;
    RST             = rst;
    ex_mem_read     = hit;
    ex_rd           = hit ? 5'd7 : 5'd0;
    id_rs1          = hit ? 5'd7 : 5'd1;
    id_uses_rs1     = 1'b1;
    id_rs2          = 5'd2;
    id_uses_rs2     = 1'b1;
    ex_branch_taken = br;
    dmem_busy       = busy;
    cnt_clr         = clr;
    e = '{n, ca, cb, sa, fa, sbv, fb};
    sb_q.push_back(e);
  endtask

  initial begin
    vec("reset", 1, 0, 0, 0, 0, C_RST, C_RST, 0, 0, 0, 0);
    vec("idle",  0, 0, 0, 0, 0, C_RUN, C_RUN, 0, 0, 0, 0);
    // x0 destination of a load must not stall
    @(negedge CLK); #1;
    ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    id_rs1 = 3; id_uses_rs1 = 1;
    sb_q.push_back('{"x0_dest", C_RUN, C_RUN, 0, 0, 0, 0});
    // matching rs1 that the instruction does not read
    @(negedge CLK); #1;
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 0;
    id_rs2 = 3; id_uses_rs2 = 1;
    sb_q.push_back('{"unused_rs1", C_RUN, C_RUN, 0, 0, 0, 0});
    // spec vector: rd=5, rs1=5, rs1 used
    @(negedge CLK); #1;
    id_uses_rs1 = 1; id_rs2 = 0; id_uses_rs2 = 0;
    sb_q.push_back('{"lu_hit", C_LU, C_LU, 0, 0, 0, 0});
    vec("lu_2",   0, 0, 0, 0, 0, C_LU,  C_RUN, 1, 0, 1, 0);
    vec("busy_1", 0, 0, 0, 1, 0, C_FRZ, C_FRZ, 2, 0, 1, 0);
    vec("busy_2", 0, 0, 0, 1, 0, C_FRZ, C_FRZ, 3, 0, 2, 0);
    vec("lu_3",   0, 0, 0, 0, 0, C_LU,  C_RUN, 4, 0, 3, 0);
    vec("lu_done",0, 0, 0, 0, 0, C_RUN, C_RUN, 5, 0, 3, 0);
    vec("br_hit", 0, 1, 1, 0, 0, C_FL,  C_FL,  5, 0, 3, 0);
    vec("post_br",0, 0, 0, 0, 0, C_RUN, C_RUN, 5, 1, 3, 1);
    vec("clr",    0, 0, 0, 0, 1, C_RUN, C_RUN, 5, 1, 3, 1);
    vec("hit_b",  0, 1, 0, 0, 0, C_LU,  C_LU,  0, 0, 0, 0);
    vec("br_stl", 0, 0, 1, 0, 0, C_FL,  C_FL,  1, 0, 1, 0);
    vec("idle_2", 0, 0, 0, 0, 0, C_RUN, C_RUN, 1, 1, 1, 1);
    vec("hit_c",  0, 1, 0, 0, 0, C_LU,  C_LU,  1, 1, 1, 1);
    vec("rst_mid",1, 0, 0, 0, 0, C_RST, C_RST, 0, 0, 0, 0);
    vec("post_rst",0,0, 0, 0, 0, C_RUN, C_RUN, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      vec("sat", 0, 0, 0, 1, 0, C_FRZ, C_FRZ,
          (i > 15) ? 15 : i, 0, i, 0);
    vec("sat_hold",0, 0, 0, 0, 0, C_RUN, C_RUN, 15, 0, 20, 0);
    vec("clr_stl", 0, 0, 0, 1, 1, C_FRZ, C_FRZ, 15, 0, 20, 0);
    vec("after_clr",0,0, 0, 0, 0, C_RUN, C_RUN, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("queue_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard/stall controller for the 5-stage OTTER pipeline. Detects load-use data hazards against the ID-stage instruction, generates taken-branch/jump flushes, and freezes the whole pipeline while data memory is busy. Supports multi-cycle load-use penalties via an internal stall counter. Keeps saturating performance counters of stall and flush cycles. Sits beside the pipeline registers, driving the PC, IF/ID and ID/EX write/flush/bubble controls.

## Interface
- REG_W, 5: register-index width.
- LOAD_USE_CYCLES, 1: bubbles per load-use hazard; legal 1..7.
- CNT_W, 32: performance-counter width.
- X0_HAZARD, 0: 0 = a destination of register 0 never causes a hazard; 1 = treat register 0 like any other register.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  REG_W each  source indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  REG_W  destination of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  the EX instruction redirects the PC (taken branch, jal, jalr).
- dmem_busy  in  1  data memory has not completed; the pipeline must freeze.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_write  out  1  PC register update enable.
- if_id_write  out  1  IF/ID register update enable.
- id_ex_write  out  1  ID/EX and later pipeline-register update enable.
- id_ex_bubble  out  1  select NOP controls into ID/EX.
- if_id_flush, id_ex_flush  out  1 each  squash that register's contents to NOP.
- stall_count, flush_count  out  CNT_W each  saturating performance counters.

## Operation
- States: RUN, LU_STALL. Internal counter lu_cnt is 3 bits wide.
- lu_hit = ex_mem_read & (X0_HAZARD | ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Output priority is highest first. Outputs are combinational (Mealy) from the state and the current inputs.
- Priority 1, dmem_busy: all write enables are 0, bubble is 0, both flushes are 0. State, lu_cnt and the counters are held, except that stall_count increments.
- Priority 2, ex_branch_taken: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=1, id_ex_flush=1, bubble=0.
  - This overrides a load-use hit, because the dependent instruction is squashed.
  - If the state is LU_STALL, go to RUN and set lu_cnt to 0.
  - flush_count increments.
- Priority 3, RUN with lu_hit: pc_write=0, if_id_write=0, id_ex_write=1, bubble=1.
  - If LOAD_USE_CYCLES > 1, go to LU_STALL with lu_cnt = LOAD_USE_CYCLES-1.
  - stall_count increments.
- Priority 3, LU_STALL: same outputs as a RUN lu_hit. lu_cnt decrements each cycle; when lu_cnt == 1, go to RUN. stall_count increments.
- Otherwise: all enables are 1, bubble is 0, flushes are 0.
- Counters saturate at all-ones and never wrap.
- cnt_clr forces both counters to 0 on the next edge and takes precedence over an increment in the same cycle.

## Timing
- Reset (asynchronous, immediate): state=RUN, lu_cnt=0, stall_count=0, flush_count=0.
- Outputs while RST is high: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=1, flushes=0.
- Zero-cycle detection latency: a hazard asserts its controls in the same cycle the operands are presented.
- A load-use hazard costs exactly LOAD_USE_CYCLES cycles of pc_write=0, counted excluding dmem_busy cycles.
- A taken branch costs exactly one flush cycle. Its 2-instruction penalty comes from the two squashed slots.
- dmem_busy mid-LU_STALL suspends lu_cnt; the countdown resumes when busy drops.
- RST mid-stall aborts the stall; the first cycle after reset deasserts runs in RUN.

## Test plan
- LOAD_USE_CYCLES=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle -> pc_write=0, if_id_write=0, bubble=1 that cycle; stall_count=1 afterwards.
- X0_HAZARD=0: ex_rd=0, id_rs2=0, id_uses_rs2=1, load in EX -> no stall. Also id_rs1=5, id_uses_rs1=0, ex_rd=5 -> no stall.
- LOAD_USE_CYCLES=3: hit, then dmem_busy high for 2 cycles during the 2nd bubble -> exactly 3 bubble cycles plus 2 frozen cycles; stall_count=5.
- lu_hit and ex_branch_taken in the same cycle -> both flushes=1, pc_write=1, bubble=0; flush_count=1, stall_count=0.
- Assert RST asynchronously mid-edge during LU_STALL (LOAD_USE_CYCLES=3) -> outputs take reset values immediately and counters read 0; after release, no residual bubble.
- CNT_W=4: 20 stall cycles -> stall_count saturates at 15. Then cnt_clr together with a stall -> 0 next cycle.
